// File: rtl/i2c_master_writer_pkg.sv
// rtl/i2c_master_writer_pkg.sv - state encodings and quarter-phase constants for the I2C write engine
package i2c_master_writer_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_BIT   = 3'd2;
    localparam logic [2:0] S_ACK   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam logic [3:0] BIT_LAST  = 4'd7;
    localparam logic [1:0] BYTE_LAST = 2'd2;

    // Open-collector lines: a *_rel flag of 1 releases the wire (z), 0 pulls it low.
    localparam logic LINE_RELEASE = 1'b1;
    localparam logic LINE_LOW     = 1'b0;

endpackage

// File: rtl/i2c_quarter_tick.sv
// rtl/i2c_quarter_tick.sv - quarter bit-period strobe with SCL stretch hold
module i2c_quarter_tick #(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic stall,
    output logic tick
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          at_last;

    // The count parks on its last value while stalled, so SCL rise time is
    // absorbed inside the quarter and only a real stretch lengthens it.
    always_comb begin
        at_last = (cnt_q == CNT_LAST);
        tick    = enable && at_last && !stall;
        cnt_d   = cnt_q;
        if (!enable) begin
            cnt_d = '0;
        end else if (at_last) begin
            if (!stall) begin
                cnt_d = '0;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/i2c_master_writer.sv
// rtl/i2c_master_writer.sv - single-master I2C writer: START, address, two data bytes, STOP
module i2c_master_writer #(
    parameter int         CLK_DIV   = 16,
    parameter logic [7:0] ADDR_BYTE = 8'h42
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        go,
    input  logic [15:0] data,
    output logic        busy,
    output logic        done,
    output logic        nack,
    inout  wire         scl,
    inout  wire         sda
);

    import i2c_master_writer_pkg::*;

    logic [2:0]  state_q,   state_d;
    logic [1:0]  phase_q,   phase_d;
    logic [3:0]  bit_q,     bit_d;
    logic [1:0]  byte_q,    byte_d;
    logic [23:0] shreg_q,   shreg_d;
    logic        scl_rel_q, scl_rel_d;
    logic        sda_rel_q, sda_rel_d;
    logic        nack_q,    nack_d;
    logic        busy_q,    busy_d;
    logic        done_q,    done_d;
    logic [1:0]  scl_sync_q, scl_sync_d;
    logic [1:0]  sda_sync_q, sda_sync_d;
    logic        tick;
    logic        stall;

    assign scl  = scl_rel_q ? 1'bz : 1'b0;
    assign sda  = sda_rel_q ? 1'bz : 1'b0;
    assign busy = busy_q;
    assign done = done_q;
    assign nack = nack_q;

    // Stretch: we let SCL go but the bus (as seen through the synchronizer) is still low.
    assign stall = scl_rel_q && !scl_sync_q[1];

    i2c_quarter_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .enable(busy_q),
        .stall (stall),
        .tick  (tick)
    );

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        bit_d      = bit_q;
        byte_d     = byte_q;
        shreg_d    = shreg_q;
        scl_rel_d  = scl_rel_q;
        sda_rel_d  = sda_rel_q;
        nack_d     = nack_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        scl_sync_d = {scl_sync_q[0], scl};
        sda_sync_d = {sda_sync_q[0], sda};

        if (state_q == S_IDLE) begin
            // done_q blocks a go issued in the same cycle as the completion pulse.
            if (go && !done_q) begin
                shreg_d   = {ADDR_BYTE, data};
                nack_d    = 1'b0;
                busy_d    = 1'b1;
                state_d   = S_START;
                phase_d   = Q0;
                bit_d     = 4'd0;
                byte_d    = 2'd0;
                scl_rel_d = LINE_RELEASE;
                sda_rel_d = LINE_LOW;
            end
        end else if (state_q > S_STOP) begin
            state_d   = S_IDLE;
            busy_d    = 1'b0;
            scl_rel_d = LINE_RELEASE;
            sda_rel_d = LINE_RELEASE;
        end else if (tick) begin
            phase_d = phase_q + 2'd1;
            case (state_q)
                S_START: begin
                    if (phase_q == Q0) begin
                        scl_rel_d = LINE_LOW;
                    end else begin
                        state_d   = S_BIT;
                        phase_d   = Q0;
                        sda_rel_d = shreg_q[23];
                    end
                end
                S_BIT: begin
                    case (phase_q)
                        Q1: scl_rel_d = LINE_RELEASE;
                        Q3: begin
                            scl_rel_d = LINE_LOW;
                            shreg_d   = {shreg_q[22:0], 1'b0};
                            bit_d     = bit_q + 4'd1;
                            if (bit_q == BIT_LAST) begin
                                state_d   = S_ACK;
                                sda_rel_d = LINE_RELEASE;
                            end else begin
                                sda_rel_d = shreg_q[22];
                            end
                        end
                        default: ;
                    endcase
                end
                S_ACK: begin
                    case (phase_q)
                        Q1: scl_rel_d = LINE_RELEASE;
                        Q2: begin
                            if (sda_sync_q[1]) begin
                                nack_d = 1'b1;
                            end
                        end
                        Q3: begin
                            scl_rel_d = LINE_LOW;
                            if (nack_q || byte_q == BYTE_LAST) begin
                                state_d   = S_STOP;
                                sda_rel_d = LINE_LOW;
                            end else begin
                                state_d   = S_BIT;
                                bit_d     = 4'd0;
                                byte_d    = byte_q + 2'd1;
                                sda_rel_d = shreg_q[23];
                            end
                        end
                        default: ;
                    endcase
                end
                S_STOP: begin
                    case (phase_q)
                        Q0: scl_rel_d = LINE_RELEASE;
                        Q1: sda_rel_d = LINE_RELEASE;
                        default: begin
                            state_d = S_IDLE;
                            phase_d = Q0;
                            bit_d   = 4'd0;
                            byte_d  = 2'd0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            phase_q    <= Q0;
            bit_q      <= 4'd0;
            byte_q     <= 2'd0;
            shreg_q    <= 24'd0;
            scl_rel_q  <= LINE_RELEASE;
            sda_rel_q  <= LINE_RELEASE;
            nack_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            shreg_q    <= shreg_d;
            scl_rel_q  <= scl_rel_d;
            sda_rel_q  <= sda_rel_d;
            nack_q     <= nack_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
        end
    end

endmodule

// File: tb/tb_i2c_master_writer.sv
// tb/tb_i2c_master_writer.sv - scoreboard bench with behavioural ACKing/stretching slave
module tb_i2c_master_writer;

    localparam int CD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        go;
    logic [15:0] data;
    logic        busy;
    logic        done;
    logic        nack;
    wire         scl_bus;
    wire         sda_bus;
    logic        scl_low = 1'b0;
    logic        sda_low = 1'b0;

    assign scl_bus = scl_low ? 1'b0 : 1'bz;
    assign sda_bus = sda_low ? 1'b0 : 1'bz;
    pullup (scl_bus);
    pullup (sda_bus);

    i2c_master_writer #(
        .CLK_DIV  (CD),
        .ADDR_BYTE(8'h42)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .go   (go),
        .data (data),
        .busy (busy),
        .done (done),
        .nack (nack),
        .scl  (scl_bus),
        .sda  (sda_bus)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        string name;
        int    act;
        int    exp;
    } imm_t;

    typedef struct {
        logic nk;
        int   lo;
        int   hi;
        int   rises;
    } done_t;

    imm_t       imm_q[$];
    logic [7:0] exp_bytes[$];
    done_t      exp_done[$];

    int total = 0;
    int bad   = 0;

    logic nack_addr   = 1'b0;
    logic stretch_arm = 1'b0;
    logic finish_req  = 1'b0;
    int   rx_count    = 0;

    // ---------------- checking (monitor process only) ----------------
    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check_range(input string nm, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d want %0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic fail_now(input string nm, input int act);
        total++;
        bad++;
        $display("FAIL %s: got 0x%0h want none", nm, act);
    endtask

    initial begin : monitor
        int         cyc;
        int         t0;
        int         rises;
        int         bitcnt;
        int         byte_idx;
        int         stretch_left;
        logic       in_ack;
        logic       stop_seen;
        logic       scl_p;
        logic       sda_p;
        logic       scl_n;
        logic       sda_n;
        logic       busy_p;
        logic [7:0] shift;
        imm_t       ic;
        done_t      ed;
        cyc = 0; t0 = 0; rises = 0; bitcnt = 0; byte_idx = 0; stretch_left = 0;
        in_ack = 1'b0; stop_seen = 1'b0; scl_p = 1'b1; sda_p = 1'b1; busy_p = 1'b0;
        shift = 8'h00;
        forever begin
            @(negedge clk);
            cyc++;
            while (imm_q.size() > 0) begin
                ic = imm_q.pop_front();
                check(ic.name, ic.act, ic.exp);
            end
            if (busy && !busy_p) t0 = cyc;
            busy_p = busy;

            if (stretch_left > 0) begin
                stretch_left--;
                if (stretch_left == 0) scl_low = 1'b0;
            end

            scl_n = scl_bus;
            sda_n = sda_bus;
            if (scl_p && scl_n && sda_p && !sda_n) begin
                bitcnt = 0; byte_idx = 0; in_ack = 1'b0; rises = 0;
                stop_seen = 1'b0; sda_low = 1'b0;
            end else if (scl_p && scl_n && !sda_p && sda_n) begin
                stop_seen = 1'b1;
            end else if (!scl_p && scl_n) begin
                rises++;
                if (!in_ack) begin
                    shift = {shift[6:0], sda_n};
                    bitcnt++;
                end
            end else if (scl_p && !scl_n) begin
                if (in_ack) begin
                    in_ack = 1'b0; sda_low = 1'b0; byte_idx++; bitcnt = 0;
                end else if (bitcnt == 8) begin
                    if (exp_bytes.size() == 0) fail_now("unexpected_byte", int'(shift));
                    else check("rx_byte", int'(shift), int'(exp_bytes.pop_front()));
                    rx_count++;
                    in_ack  = 1'b1;
                    sda_low = !(nack_addr && byte_idx == 0);
                end else if (stretch_arm && byte_idx == 1 && bitcnt == 3) begin
                    scl_low      = 1'b1;
                    stretch_left = 2 * CD + 50;
                end
            end
            scl_p = scl_n;
            sda_p = sda_n;

            if (done) begin
                if (exp_done.size() == 0) begin
                    fail_now("unexpected_done", cyc);
                end else begin
                    ed = exp_done.pop_front();
                    check("done_nack", int'(nack), int'(ed.nk));
                    check_range("done_latency", cyc - t0, ed.lo, ed.hi);
                    check("scl_rises", rises, ed.rises);
                    check("stop_seen", int'(stop_seen), 1);
                end
            end

            if (finish_req || cyc > 30000) begin
                if (!finish_req) fail_now("watchdog", cyc);
                check("exp_bytes_left", exp_bytes.size(), 0);
                check("exp_done_left", exp_done.size(), 0);
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc_wait(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_now(input string nm, input int act, input int exp);
        imm_t t;
        t.name = nm;
        t.act  = act;
        t.exp  = exp;
        imm_q.push_back(t);
    endtask

    task automatic push_tx(input logic [15:0] d, input logic nk, input int lo, input int hi);
        done_t e;
        exp_bytes.push_back(8'h42);
        if (!nk) begin
            exp_bytes.push_back(d[15:8]);
            exp_bytes.push_back(d[7:0]);
        end
        e.nk    = nk;
        e.lo    = lo;
        e.hi    = hi;
        e.rises = nk ? 10 : 28;
        exp_done.push_back(e);
    endtask

    task automatic issue(input logic [15:0] d);
        go   = 1'b1;
        data = d;
        cyc_wait(1);
        go   = 1'b0;
        expect_now("go_accept_busy", int'(busy), 1);
    endtask

    task automatic wait_done(input int lim);
        logic got;
        got = 1'b0;
        for (int i = 0; i < lim && !got; i++) begin
            cyc_wait(1);
            if (done) got = 1'b1;
        end
        expect_now("done_seen", int'(got), 1);
    endtask

    initial begin : stimulus
        int rc;
        reset = 1'b1;
        go    = 1'b0;
        data  = 16'h0000;
        cyc_wait(3);
        expect_now("rst_busy", int'(busy), 0);
        expect_now("rst_done", int'(done), 0);
        expect_now("rst_nack", int'(nack), 0);
        expect_now("rst_scl", int'(scl_bus), 1);
        expect_now("rst_sda", int'(sda_bus), 1);
        reset = 1'b0;
        cyc_wait(2);

        push_tx(16'hBEEF, 1'b0, 113 * CD, 113 * CD);
        issue(16'hBEEF);
        wait_done(1000);
        go   = 1'b1;
        data = 16'h0000;
        cyc_wait(1);
        go   = 1'b0;
        expect_now("go_in_done_ignored", int'(busy), 0);
        cyc_wait(3);

        push_tx(16'h1234, 1'b0, 113 * CD, 113 * CD);
        issue(16'h1234);
        cyc_wait(100);
        go   = 1'b1;
        data = 16'hFFFF;
        cyc_wait(1);
        go   = 1'b0;
        wait_done(1000);
        cyc_wait(3);

        nack_addr = 1'b1;
        push_tx(16'hCAFE, 1'b1, 41 * CD, 41 * CD);
        issue(16'hCAFE);
        wait_done(1000);
        nack_addr = 1'b0;
        cyc_wait(5);
        expect_now("nack_hold", int'(nack), 1);

        stretch_arm = 1'b1;
        push_tx(16'hA55A, 1'b0, 113 * CD + 50 - CD, 113 * CD + 50 + CD);
        issue(16'hA55A);
        expect_now("nack_cleared", int'(nack), 0);
        wait_done(1200);
        stretch_arm = 1'b0;
        cyc_wait(3);

        exp_bytes.push_back(8'h42);
        rc = rx_count;
        issue(16'h1357);
        for (int i = 0; i < 500 && rx_count == rc; i++) cyc_wait(1);
        expect_now("abort_addr_seen", int'(rx_count != rc), 1);
        cyc_wait(30);
        reset = 1'b1;
        cyc_wait(1);
        expect_now("abort_busy", int'(busy), 0);
        expect_now("abort_scl", int'(scl_bus), 1);
        expect_now("abort_sda", int'(sda_bus), 1);
        expect_now("abort_done", int'(done), 0);
        reset = 1'b0;
        cyc_wait(3);

        reset = 1'b1;
        go    = 1'b1;
        data  = 16'hFFFF;
        cyc_wait(1);
        reset = 1'b0;
        go    = 1'b0;
        cyc_wait(1);
        expect_now("go_with_reset_ignored", int'(busy), 0);
        cyc_wait(3);

        push_tx(16'h00FF, 1'b0, 113 * CD, 113 * CD);
        issue(16'h00FF);
        wait_done(1000);
        cyc_wait(5);
        finish_req = 1'b1;
        cyc_wait(20);
    end

endmodule
